// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared definitions for the instruction-memory arbiter slice: default
//   memory geometry, FSM state and port-id enumerations, and the address
//   legality helper used by the top level.
//   Ports: none (package).
package imem_pkg;

  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0100_0000;
  localparam int          DEF_IMEM_DEPTH = 512;
  localparam int          DEF_ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } imem_st_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } imem_port_t;

  // Word-aligned and inside [base, last]; last is the final word address,
  // so the compare never needs base + size, which could wrap.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] last);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/imem_grant.sv
// imem_grant
//   Two-way grant selection between the fetch (F) and debug (D) requesters.
//   Purely combinational; the caller decides when a grant may be used.
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   - on contention, grant the port that did not win last time
//     undefined - on contention, F always wins (D may starve)
//   Ports:
//     valid_f, valid_d  in   request valids
//     last_grant        in   port of the previous handshake (macro builds only)
//     gnt_valid         out  at least one request is present
//     gnt               out  granted port (0 = F, 1 = D)
module imem_grant
  import imem_pkg::*;
(
  input  logic valid_f,
  input  logic valid_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic gnt_valid,
  output logic gnt
);

  always_comb begin
    gnt_valid = valid_f | valid_d;
    gnt       = PORT_F;
    if (valid_f && valid_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt = (last_grant == PORT_F) ? PORT_D : PORT_F;
`else
      gnt = PORT_F;
`endif
    end else if (valid_d) begin
      gnt = PORT_D;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-ported, 1-cycle-read instruction memory between the core
//   fetch port (F) and the debug/program-check port (D). Each accepted request
//   is range/alignment checked, read from memory if legal, and its response is
//   held until the owning port accepts it. Illegal requests skip the memory,
//   return err=1/data=0 and bump a saturating error counter.
//   Configuration macro: ARB_ROUND_ROBIN_EN (round-robin on contention;
//   otherwise fixed priority with F winning).
//   Ports:
//     clk, rst                      clock (rising edge), async active-high reset
//     f_req_valid/addr/ready        fetch request handshake
//     f_rsp_valid/data/err/ready    fetch response handshake
//     d_*                           same seven signals for the debug port
//     mem_read_instr, mem_addr      read strobe and address to the memory
//     mem_instr                     memory data, valid one clock after strobe
//     err_cnt                       saturating count of illegal requests
module imem_arbiter
  import imem_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
  parameter int          IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int          ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_req_valid,
  input  logic [31:0]          f_req_addr,
  output logic                 f_req_ready,
  output logic                 f_rsp_valid,
  output logic [31:0]          f_rsp_data,
  output logic                 f_rsp_err,
  input  logic                 f_rsp_ready,
  input  logic                 d_req_valid,
  input  logic [31:0]          d_req_addr,
  output logic                 d_req_ready,
  output logic                 d_rsp_valid,
  output logic [31:0]          d_rsp_data,
  output logic                 d_rsp_err,
  input  logic                 d_rsp_ready,
  output logic                 mem_read_instr,
  output logic [31:0]          mem_addr,
  input  logic [31:0]          mem_instr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(4 * IMEM_DEPTH) - 32'd4;

  imem_st_t             state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 gnt_valid;
  logic                 gnt;
  logic                 hs;
  logic [31:0]          req_addr;
  logic                 req_legal;
  logic                 owner_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic                 last_grant_q, last_grant_d;
`endif

  imem_grant u_grant (
    .valid_f    (f_req_valid),
    .valid_d    (d_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // rsp_valid rises one edge after RSP is entered, which gives the memory its
  // cycle to present data for legal reads and keeps illegal responses at one
  // cycle of latency with the same FSM shape.
  always_comb begin
    hs          = (state_q == IDLE) && gnt_valid;
    req_addr    = (gnt == PORT_D) ? d_req_addr : f_req_addr;
    req_legal   = addr_legal(req_addr, IMEM_BASE, IMEM_LAST);
    owner_ready = (owner_q == PORT_D) ? d_rsp_ready : f_rsp_ready;

    state_d     = state_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    mem_addr_d  = mem_addr_q;
    err_cnt_d   = err_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d    = gnt;
          mem_addr_d = req_addr;
          rsp_data_d = '0;
          rsp_err_d  = ~req_legal;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = gnt;
`endif
          if (req_legal) begin
            state_d = RD;
          end else begin
            state_d = RSP;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
          end
        end
      end
      RD: begin
        state_d = RSP;
      end
      RSP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          if (!rsp_err_q) begin
            rsp_data_d = mem_instr;
          end
        end else if (owner_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_F;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Starts at D so the first contended grant goes to F.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Ready is gated by rst so a requester holding valid through reset is not
  // told it was accepted.
  assign f_req_ready    = ~rst & hs & (gnt == PORT_F);
  assign d_req_ready    = ~rst & hs & (gnt == PORT_D);

  assign f_rsp_valid    = rsp_valid_q & (owner_q == PORT_F);
  assign d_rsp_valid    = rsp_valid_q & (owner_q == PORT_D);
  assign f_rsp_data     = f_rsp_valid ? rsp_data_q : '0;
  assign d_rsp_data     = d_rsp_valid ? rsp_data_q : '0;
  assign f_rsp_err      = f_rsp_valid & rsp_err_q;
  assign d_rsp_err      = d_rsp_valid & rsp_err_q;

  assign mem_read_instr = (state_q == RD);
  assign mem_addr       = mem_addr_q;
  assign err_cnt        = err_cnt_q;

endmodule
